// File: rtl/register_file.sv
// RISC-V integer register file: 31 stored registers (x0 hardwired to zero),
// two combinational read ports with optional write-through, one write port, debug read.
module register_file #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(32'h0000_3FFC),
  parameter logic [XLEN-1:0] GP_RESET = XLEN'(32'h0000_1800),
  parameter int unsigned BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [31:0]     wr_count
);

  localparam int unsigned NREGS = 32;
  localparam bit          BYP   = (BYPASS != 0);

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [XLEN-1:0] view [0:NREGS-1];
  logic            wr_en;

  assign wr_en = we && (rd != 5'd0);

  // Storage and commit counter; reset values are architectural (sp, gp).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        if (i == 2)      regs[i] <= SP_RESET;
        else if (i == 3) regs[i] <= GP_RESET;
        else             regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (wr_en) begin
      regs[rd] <= wd;
      wr_count <= wr_count + 32'd1;
    end
  end

  // Full 32-entry view with x0 reading as zero, so address decode needs no guard.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      view[i] = regs[i];
    end
  end

  always_comb begin
    rd1 = view[rs1];
    rd2 = view[rs2];
    if (BYP && wr_en && (rd == rs1)) rd1 = wd;
    if (BYP && wr_en && (rd == rs2)) rd2 = wd;
  end

  assign dbg_data = view[dbg_addr];

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed check of register_file (BYPASS=1 and BYPASS=0 instances)
// against an array-based architectural model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd, dbg_addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] b_rd1, b_rd2, b_dbg, b_cnt;
  logic [31:0] n_rd1, n_rd2, n_dbg, n_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  logic [31:0] cnt;

  always #5 clk = ~clk;

  register_file #(.XLEN(32), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .we(we), .wd(wd),
    .rd1(b_rd1), .rd2(b_rd2), .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wr_count(b_cnt)
  );

  register_file #(.XLEN(32), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .we(we), .wd(wd),
    .rd1(n_rd1), .rd2(n_rd2), .dbg_addr(dbg_addr), .dbg_data(n_dbg), .wr_count(n_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mem[i]) mem[i] = 32'd0;
    mem[2] = 32'h0000_3FFC;
    mem[3] = 32'h0000_1800;
    cnt = 32'd0;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) model_reset();
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we && rd == a) return wd;
    return mem[a];
  endfunction

  task automatic check_all(input string tag);
    check({tag, " byp.rd1"},   b_rd1, exp_read(rs1, 1'b1));
    check({tag, " byp.rd2"},   b_rd2, exp_read(rs2, 1'b1));
    check({tag, " byp.dbg"},   b_dbg, exp_read(dbg_addr, 1'b0));
    check({tag, " byp.cnt"},   b_cnt, cnt);
    check({tag, " nob.rd1"},   n_rd1, exp_read(rs1, 1'b0));
    check({tag, " nob.rd2"},   n_rd2, exp_read(rs2, 1'b0));
    check({tag, " nob.dbg"},   n_dbg, exp_read(dbg_addr, 1'b0));
    check({tag, " nob.cnt"},   n_cnt, cnt);
  endtask

  // Check pre-edge outputs, take one rising edge, commit the architectural effect.
  task automatic tick(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    if (!rst && we && rd != 5'd0) begin
      mem[rd] = wd;
      cnt = cnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    rs1 = '0; rs2 = '0; rd = '0; dbg_addr = '0; we = 1'b0; wd = '0;
    set_rst(1'b1);

    // Reset contents on every address
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); rs1 = 5'(i); rs2 = 5'(31 - i);
      #1 check_all("reset");
    end
    @(negedge clk);
    set_rst(1'b0);
    @(posedge clk); #1;

    // Basic write then read back
    we = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF;
    tick("wr5");
    we = 1'b0; rs1 = 5'd5; rs2 = 5'd5; dbg_addr = 5'd5;
    #1 check(" rd1 x5", n_rd1, 32'hDEADBEEF);
    check("cnt after x5", n_cnt, 32'd1);
    check_all("rd5");

    // x0 stays zero and does not count
    we = 1'b1; rd = 5'd0; wd = 32'h12345678; rs1 = 5'd0;
    tick("wr0");
    we = 1'b0;
    #1 check("x0 read", b_rd1, 32'd0);
    check("cnt after x0", b_cnt, 32'd1);

    // Write-through vs. registered read
    we = 1'b1; rd = 5'd7; wd = 32'hAAAAAAAA; rs2 = 5'd7; dbg_addr = 5'd7;
    #1 check("bypass rd2", b_rd2, 32'hAAAAAAAA);
    check("nobypass rd2 pre", n_rd2, 32'd0);
    check("dbg no bypass", b_dbg, 32'd0);
    tick("wr7");
    we = 1'b0;
    #1 check("nobypass rd2 post", n_rd2, 32'hAAAAAAAA);
    check_all("rd7");

    // Async reset mid-cycle wipes x9 and blocks a held write
    we = 1'b1; rd = 5'd9; wd = 32'hBBBBBBBB;
    tick("wr9");
    we = 1'b0; dbg_addr = 5'd9;
    #1 check("x9 written", n_dbg, 32'hBBBBBBBB);
    #2 set_rst(1'b1);
    #1 check("x9 async clear", n_dbg, 32'd0);
    check("cnt async clear", n_cnt, 32'd0);
    we = 1'b1; rd = 5'd9; wd = 32'hCCCCCCCC;
    tick("held wr in rst");
    we = 1'b0;
    #1 check("x9 after rst write", n_dbg, 32'd0);
    check_all("in rst");
    @(negedge clk);
    set_rst(1'b0);
    @(posedge clk); #1;

    // Sweep all registers, then read every pair
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; rd = 5'(i); wd = i * 32'h0101_0101;
      tick("sweep wr");
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'((i * 7 + 3) % 32); dbg_addr = 5'(31 - i);
      #1 check_all("sweep rd");
    end
    check("sweep cnt", n_cnt, 32'd31);
    check("x31", mem[31] ^ 32'h1F1F_1F1F, 32'd0);

    // Random traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      rs1 = 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      rd  = ($urandom_range(0, 2) == 0) ? rs1 : 5'($urandom_range(0, 31));
      dbg_addr = 5'($urandom_range(0, 31));
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      set_rst($urandom_range(0, 39) == 0);
      tick("rand");
    end
    set_rst(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file for the RISC-V single-cycle core: 32 × 32-bit registers, two combinational read ports, one synchronous write port, and a debug read port. Sits directly upstream of the operand-select multiplexer. Read port 2 is that multiplexer's register-side input, and the immediate is its other input. Write-back data arrives from the result-select stage at the end of each cycle.

## Interface
Parameters:
- XLEN, 32, register and data width
- SP_RESET, 32'h0000_3FFC, reset value of x2 (sp)
- GP_RESET, 32'h0000_1800, reset value of x3 (gp)
- BYPASS, 1, 1 = a read of the register being written this cycle returns the write data; 0 = it returns the stored value

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- rs1  in  5  read address, port 1
- rs2  in  5  read address, port 2
- rd  in  5  write address
- we  in  1  write enable
- wd  in  XLEN  write data
- rd1  out  XLEN  read data, port 1
- rd2  out  XLEN  read data, port 2 (to operand mux)
- dbg_addr  in  5  debug read address
- dbg_data  out  XLEN  debug read data, no bypass
- wr_count  out  32  count of committed writes (rd≠0), for bench and debug

## Operation
- Storage holds 31 registers, x1..x31. x0 is not stored; any read of address 0 returns 0.
- Reset (rst=1, asynchronous, takes effect immediately):
  - x2 ← SP_RESET, x3 ← GP_RESET, all other registers ← 0.
  - wr_count ← 0.
  - Writes are blocked for as long as rst is high.
- Write: on a rising clk edge with rst=0 and we=1:
  - if rd≠0: x[rd] ← wd and wr_count ← wr_count+1;
  - if rd=0: the write is discarded and wr_count is unchanged.
- wr_count wraps from 32'hFFFF_FFFF to 0.
- Read ports 1/2, purely combinational:
  - if rsN=0: rdN = 0;
  - else if BYPASS=1 and we=1 and rd=rsN: rdN = wd;
  - else: rdN = x[rsN].
- Debug port: dbg_data = 0 when dbg_addr=0, else x[dbg_addr]. It never bypasses.
- rs1=rs2 is legal; both ports return the same value.
- Outputs during reset:
  - rd1 and rd2 show reset contents (0, SP_RESET or GP_RESET by address), or wd when BYPASS=1, we=1 and the address matches.
  - dbg_data shows reset contents by address.
  - wr_count = 0.
- No X propagation: every register has a defined reset value.

## Timing
- Read latency: 0 cycles, combinational from rs1/rs2/dbg_addr and the current storage.
- Write latency: 1 edge. The stored value is visible on the non-bypassed path from the cycle after the edge.
- With BYPASS=1, the read path contains wd → rdN combinationally. Integration must not close a loop wd→rd2→operand mux→ALU→wd within the same cycle. The single-cycle core therefore instantiates BYPASS=0. BYPASS=1 is reserved for pipelined reuse.
- Reset deassertion: the first write can occur on the first rising edge after rst falls, provided reset recovery time is met.
- Reset asserted mid-write (rst rises before the edge): the write is lost and the register holds its reset value.
- Same-edge write and read of the same address with BYPASS=0: the read sees the old value until the edge, then the new value.

## Test plan
1. Reset: assert rst, set dbg_addr = 0..31 -> dbg_data = 0 for all except addr 2 = 32'h0000_3FFC and addr 3 = 32'h0000_1800; wr_count = 0.
2. Write/read: we=1, rd=5, wd=32'hDEADBEEF, one edge; then rs1=5, rs2=5 -> rd1 = rd2 = 32'hDEADBEEF; wr_count = 1.
3. x0 immutability: we=1, rd=0, wd=32'h12345678, one edge -> rs1=0 gives rd1 = 0; wr_count unchanged.
4. Write-through: BYPASS=1, we=1, rd=7, wd=32'hAAAAAAAA, rs2=7 before the edge -> rd2 = 32'hAAAAAAAA combinationally, while dbg_data (dbg_addr=7) still shows the old value 0. With BYPASS=0 -> rd2 = 0 until the edge, then 32'hAAAAAAAA.
5. Async reset mid-operation: x9 = 32'hBBBBBBBB written; assert rst between edges -> dbg_data (addr 9) = 0 immediately, without waiting for an edge. A write held through the next edge while rst=1 has no effect.
6. Sweep: write x[i] = i·32'h0101_0101 for i = 1..31 over 31 edges; read back all pairs via rs1/rs2 -> every value matches and wr_count = 31.
